ps2_key_decoder: RTL

// - Receives PS/2 keyboard frames (set-2 scancodes) and turns make/break codes into

---
 rtl/bomberman_kbd_pkg.sv | 58 +++++
 rtl/ps2_key_decoder_if.sv | 27 ++
 rtl/ps2_rx_frame.sv | 114 +++++++++++
 rtl/ps2_key_decoder.sv | 66 ++++++
 4 files changed

// File: rtl/bomberman_kbd_pkg.sv
// Shared scancode constants, frame FSM states and the key-flag lookup used by
// the PS/2 keyboard decoder.
package bomberman_kbd_pkg;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;
   localparam logic [7:0] SC_UP  = 8'h75;
   localparam logic [7:0] SC_DN  = 8'h72;
   localparam logic [7:0] SC_LT  = 8'h6B;
   localparam logic [7:0] SC_RT  = 8'h74;
   localparam logic [7:0] SC_Z   = 8'h1A;
   localparam logic [7:0] SC_S   = 8'h1B;
   localparam logic [7:0] SC_Q   = 8'h15;
   localparam logic [7:0] SC_D   = 8'h23;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_e;

   typedef enum logic [2:0] {
      K_J1_UP, K_J1_DN, K_J1_LT, K_J1_RT,
      K_J2_UP, K_J2_DN, K_J2_LT, K_J2_RT
   } key_e;

   typedef struct packed {
      logic hit;
      key_e key;
   } key_hit_t;

   // Arrow keys only match behind the E0 prefix; the keypad twins share the byte.
   function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
      key_hit_t r;
      r.hit = 1'b1;
      r.key = K_J1_UP;
      if (ext) begin
         case (code)
            SC_UP:   r.key = K_J1_UP;
            SC_DN:   r.key = K_J1_DN;
            SC_LT:   r.key = K_J1_LT;
            SC_RT:   r.key = K_J1_RT;
            default: r.hit = 1'b0;
         endcase
      end else begin
         case (code)
            SC_Z:    r.key = K_J2_UP;
            SC_S:    r.key = K_J2_DN;
            SC_Q:    r.key = K_J2_LT;
            SC_D:    r.key = K_J2_RT;
            default: r.hit = 1'b0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Board-facing PS/2 pins plus the decoded key flags and raw byte stream
// handed to the game controller.
interface ps2_key_decoder_if;

   logic       ps2_clk;
   logic       ps2_data;
   logic       j1_up, j1_down, j1_left, j1_right;
   logic       j2_up, j2_down, j2_left, j2_right;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       frame_err;

   modport slave (
      input  ps2_clk, ps2_data,
      output j1_up, j1_down, j1_left, j1_right,
      output j2_up, j2_down, j2_left, j2_right,
      output rx_byte, rx_valid, frame_err
   );

   modport master (
      output ps2_clk, ps2_data,
      input  j1_up, j1_down, j1_left, j1_right,
      input  j2_up, j2_down, j2_left, j2_right,
      input  rx_byte, rx_valid, frame_err
   );

endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the keyboard lines, detects falling clock
// edges and assembles 11-bit frames, dropping stalled partial frames.
module ps2_rx_frame
   import bomberman_kbd_pkg::*;
#(
   parameter int TIMEOUT_CYC = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic                   clk_prev;
   logic                   fall, data_bit;

   frame_state_e state, state_n;
   logic [2:0]   bit_cnt, bit_cnt_n;
   logic [7:0]   shreg, shreg_n, byte_n;
   logic         par_bit, par_bit_n;
   logic [TW-1:0] to_cnt, to_cnt_n;
   logic         valid_n, err_n, timeout_hit;

   // Synchronisers reset high: the idle PS/2 line is high, so no false edge leaves reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign fall        = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign data_bit    = data_sync[SYNC_STAGES-1];
   assign timeout_hit = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYC));

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_bit_n = par_bit;
      byte_n    = rx_byte;
      valid_n   = 1'b0;
      err_n     = 1'b0;
      to_cnt_n  = (fall || state == ST_IDLE) ? '0 : to_cnt + TW'(1);
      if (fall) begin
         case (state)
            ST_IDLE: if (!data_bit) begin
               state_n   = ST_DATA;
               bit_cnt_n = 3'd0;
            end
            ST_DATA: begin
               shreg_n   = {data_bit, shreg[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = ST_PARITY;
            end
            ST_PARITY: begin
               par_bit_n = data_bit;
               state_n   = ST_STOP;
            end
            ST_STOP: begin
               if (data_bit && (^{shreg, par_bit})) begin
                  valid_n = 1'b1;
                  byte_n  = shreg;
               end else begin
                  err_n = 1'b1;
               end
               state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end else if (timeout_hit) begin
         state_n  = ST_IDLE;
         err_n    = 1'b1;
         to_cnt_n = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         par_bit   <= 1'b0;
         to_cnt    <= '0;
         rx_byte   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         par_bit   <= par_bit_n;
         to_cnt    <= to_cnt_n;
         rx_byte   <= byte_n;
         rx_valid  <= valid_n;
         frame_err <= err_n;
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 set-2 make/break scancodes into level "key held" flags for the
// two players' direction commands.
module ps2_key_decoder
   import bomberman_kbd_pkg::*;
#(
   parameter int TIMEOUT_CYC = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   ps2_key_decoder_if.slave   bus
);

   logic [7:0] rx_byte;
   logic       rx_valid, frame_err;
   logic       ext, brk;
   logic [7:0] keys;
   key_hit_t   hit;

   ps2_rx_frame #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx (
      .clk       (clk),
      .reset_n   (reset_n),
      .ps2_clk   (bus.ps2_clk),
      .ps2_data  (bus.ps2_data),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   assign hit = key_lookup(ext, rx_byte);

   // Prefixes survive frame errors; only a real non-prefix byte consumes them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ext  <= 1'b0;
         brk  <= 1'b0;
         keys <= 8'h00;
      end else if (rx_valid) begin
         if (rx_byte == SC_EXT) begin
            ext <= 1'b1;
         end else if (rx_byte == SC_BRK) begin
            brk <= 1'b1;
         end else begin
            if (hit.hit) keys[hit.key] <= ~brk;
            ext <= 1'b0;
            brk <= 1'b0;
         end
      end
   end

   assign bus.j1_up     = keys[K_J1_UP];
   assign bus.j1_down   = keys[K_J1_DN];
   assign bus.j1_left   = keys[K_J1_LT];
   assign bus.j1_right  = keys[K_J1_RT];
   assign bus.j2_up     = keys[K_J2_UP];
   assign bus.j2_down   = keys[K_J2_DN];
   assign bus.j2_left   = keys[K_J2_LT];
   assign bus.j2_right  = keys[K_J2_RT];
   assign bus.rx_byte   = rx_byte;
   assign bus.rx_valid  = rx_valid;
   assign bus.frame_err = frame_err;

endmodule
